// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between the EX stage (master) and the
// iterative multiply/divide unit (slave).
interface mdu_iter_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, hi, lo, div_by_zero
   );
endinterface

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Build option: define MDU_DIV_EN to include the restoring divider datapath.
//
// state   | meaning
// IDLE    | waiting for start; MTHI/MTLO and zero-divisor ops complete here
// CALC    | one shift-add / shift-subtract iteration per cycle, WIDTH cycles
// FIX     | sign correction, HI/LO commit, done pulse
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input logic       clk,
   input logic       rstn,
   mdu_iter_if.slave bus
);
   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_FIX
   } state_e;

   localparam int            CW       = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic                 neg_q, neg_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 dbz_q, dbz_d;
   logic                 zpend_q, zpend_d;
`ifdef MDU_DIV_EN
   logic                 is_div_q, is_div_d;
   logic                 neg_r_q, neg_r_d;
`endif

   logic                 accept;
   logic                 op_signed;
   logic                 sign_xor;
   logic [WIDTH-1:0]     abs_a;
   logic [WIDTH-1:0]     abs_b;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [2*WIDTH-1:0]   prod_fix;

   assign accept    = ~busy_q & bus.start;
   assign op_signed = ~bus.op[0];
   assign sign_xor  = op_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
   assign abs_a     = (op_signed & bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign abs_b     = (op_signed & bus.b[WIDTH-1]) ? -bus.b : bus.b;

   // acc holds {partial product, remaining multiplier bits}
   assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
   assign mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]}
                              : {1'b0, acc_q[2*WIDTH-1:1]};
   assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef MDU_DIV_EN
   logic [WIDTH-1:0]     div_trial;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;

   // acc holds {partial remainder, dividend bits / quotient bits}; the
   // remainder stays below the divisor, so the low WIDTH bits of the trial
   // difference are exact whenever the subtraction is taken.
   assign div_trial = acc_q[2*WIDTH-2:WIDTH-1] - opnd_q;
   assign div_ge    = acc_q[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd_q};
   assign div_next  = div_ge ? {div_trial, acc_q[WIDTH-2:0], 1'b1}
                             : {acc_q[2*WIDTH-2:0], 1'b0};
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      dbz_d   = dbz_q;
      zpend_d = 1'b0;
`ifdef MDU_DIV_EN
      is_div_d = is_div_q;
      neg_r_d  = neg_r_q;
`endif

      // zero-divisor / no-divider requests complete one edge after accept
      if (zpend_q) begin
         done_d = 1'b1;
`ifdef MDU_DIV_EN
         dbz_d  = 1'b1;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (bus.op)
                  OP_MULT, OP_MULTU: begin
                     dbz_d   = 1'b0;
                     acc_d   = {{WIDTH{1'b0}}, abs_b};
                     opnd_d  = abs_a;
                     neg_d   = sign_xor;
                     cnt_d   = '0;
                     busy_d  = 1'b1;
                     state_d = ST_CALC;
`ifdef MDU_DIV_EN
                     is_div_d = 1'b0;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     dbz_d = 1'b0;
`ifdef MDU_DIV_EN
                     if (bus.b == '0) begin
                        zpend_d = 1'b1;
                     end else begin
                        acc_d    = {{WIDTH{1'b0}}, abs_a};
                        opnd_d   = abs_b;
                        neg_d    = sign_xor;
                        neg_r_d  = op_signed & bus.a[WIDTH-1];
                        is_div_d = 1'b1;
                        cnt_d    = '0;
                        busy_d   = 1'b1;
                        state_d  = ST_CALC;
                     end
`else
                     zpend_d = 1'b1;
`endif
                  end
                  OP_MTHI: begin
                     dbz_d = 1'b0;
                     hi_d  = bus.a;
                  end
                  OP_MTLO: begin
                     dbz_d = 1'b0;
                     lo_d  = bus.a;
                  end
                  default: ;
               endcase
            end
         end

         ST_CALC: begin
`ifdef MDU_DIV_EN
            acc_d = is_div_q ? div_next : mul_next;
`else
            acc_d = mul_next;
`endif
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = ST_FIX;
            end
         end

         ST_FIX: begin
`ifdef MDU_DIV_EN
            if (is_div_q) begin
               lo_d = neg_q   ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
               hi_d = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end else begin
               {hi_d, lo_d} = prod_fix;
            end
`else
            {hi_d, lo_d} = prod_fix;
`endif
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         zpend_q  <= 1'b0;
`ifdef MDU_DIV_EN
         is_div_q <= 1'b0;
         neg_r_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         zpend_q  <= zpend_d;
`ifdef MDU_DIV_EN
         is_div_q <= is_div_d;
         neg_r_q  <= neg_r_d;
`endif
      end
   end

   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.hi          = hi_q;
   assign bus.lo          = lo_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (WIDTH=32); adapts expectations to MDU_DIV_EN.
module tb_mdu_iter;
`ifdef MDU_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                          MTHI = 3'd4, MTLO = 3'd5, RSVD = 3'd6;

   logic clk;
   logic rstn;
   int   total;
   int   bad;

   mdu_iter_if #(.WIDTH(32)) bus ();
   mdu_iter #(.WIDTH(32)) dut (.clk(clk), .rstn(rstn), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic add_vec(input logic [2:0] op, input logic [31:0] a, b, hi, lo,
                          input logic dz, input int lat);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.dz = dz; v.lat = lat;
      vecs.push_back(v);
   endtask

   // Latency counts edges after the accept edge until done is seen (bounded);
   // -1 flags a done pulse from an op that must not produce one.
   task automatic apply(input logic [2:0] op_v, input logic [31:0] a_v, b_v,
                        output int lat, output int bcyc);
      @(negedge clk);
      bus.start = 1'b1; bus.op = op_v; bus.a = a_v; bus.b = b_v;
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat  = 0;
      bcyc = bus.busy ? 1 : 0;
      if (op_v <= DIVU) begin
         while (!bus.done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (bus.busy) bcyc++;
         end
      end else begin
         if (bus.done) lat = -1;
         repeat (2) begin
            @(posedge clk); #1;
            if (bus.done) lat = -1;
         end
      end
   endtask

   // Reference model: plain arithmetic on the architectural definition.
   function automatic void ref_op(input logic [2:0] op, input logic [31:0] a, b,
                                  input logic [31:0] hi0, lo0, input logic dz0,
                                  output logic [31:0] hi1, lo1, output logic dz1,
                                  output int lat);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi1 = hi0; lo1 = lo0; dz1 = dz0; lat = 0;
      case (op)
         MULT: begin
            p = 64'(sa * sb);
            {hi1, lo1} = p; dz1 = 1'b0; lat = 33;
         end
         MULTU: begin
            p = {32'h0, a} * {32'h0, b};
            {hi1, lo1} = p; dz1 = 1'b0; lat = 33;
         end
         DIV, DIVU: begin
            lat = 1; dz1 = 1'b0;
            if (DIV_EN) begin
               if (b == 32'h0) begin
                  dz1 = 1'b1;
               end else begin
                  lat = 33;
                  if (op == DIV) begin
                     q = sa / sb; r = sa % sb;
                     lo1 = q[31:0]; hi1 = r[31:0];
                  end else begin
                     lo1 = a / b; hi1 = a % b;
                  end
               end
            end
         end
         MTHI: begin hi1 = a; dz1 = 1'b0; end
         MTLO: begin lo1 = a; dz1 = 1'b0; end
         default: ;
      endcase
   endfunction

   initial begin
      int          lat, bcyc, n;
      logic        hold_ok;
      logic [31:0] m_hi, m_lo, e_hi, e_lo;
      logic        m_dz, e_dz;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          sel;

      total = 0; bad = 0;
      rstn = 1'b0;
      bus.start = 1'b0; bus.op = 3'd0; bus.a = 32'h0; bus.b = 32'h0;

      #3;
      chk("rst_hi", bus.hi, 0);
      chk("rst_lo", bus.lo, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_dbz", bus.div_by_zero, 0);
      @(negedge clk); rstn = 1'b1;

      add_vec(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33);
      add_vec(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33);
      if (DIV_EN) begin
         add_vec(DIVU, 32'd7,        32'd2,        32'd1,        32'd3,        1'b0, 33);
         add_vec(DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33);
         add_vec(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 33);
      end else begin
         add_vec(DIV,  32'd9,        32'd3,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1);
      end
      add_vec(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        1'b0, 33);
      add_vec(MTHI,  32'h11,       32'h0,        32'h11,       32'h0,        1'b0, 0);
      add_vec(MTLO,  32'h22,       32'h0,        32'h11,       32'h22,       1'b0, 0);
      add_vec(RSVD,  32'hDEAD,     32'hBEEF,     32'h11,       32'h22,       1'b0, 0);
      add_vec(DIV,   32'd5,        32'd0,        32'h11,       32'h22,       DIV_EN, 1);
      add_vec(MULT,  32'd3,        32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 33);

      foreach (vecs[i]) begin
         apply(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcyc);
         chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
         chk($sformatf("vec%0d_busy", i), bcyc, (vecs[i].lat == 33) ? 33 : 0);
         chk($sformatf("vec%0d_hi", i), bus.hi, vecs[i].hi);
         chk($sformatf("vec%0d_lo", i), bus.lo, vecs[i].lo);
         chk($sformatf("vec%0d_dbz", i), bus.div_by_zero, vecs[i].dz);
      end

      // MTHI during a multiply is dropped; HI shows the old value until done
      apply(MTHI, 32'hAAAA0000, 32'h0, lat, bcyc);
      chk("pre_mthi", bus.hi, 32'hAAAA0000);
      @(negedge clk);
      bus.start = 1'b1; bus.op = MULT; bus.a = 32'd5; bus.b = 32'd6;
      @(posedge clk); #1;
      bus.start = 1'b0;
      n = 0; hold_ok = 1'b1;
      while (!bus.done && n < 100) begin
         if (n == 4) begin
            bus.start = 1'b1; bus.op = MTHI; bus.a = 32'h12345678;
         end else begin
            bus.start = 1'b0;
         end
         @(posedge clk); #1;
         n++;
         if (!bus.done && bus.hi !== 32'hAAAA0000) hold_ok = 1'b0;
      end
      bus.start = 1'b0;
      chk("busy_hold_hi", hold_ok, 1'b1);
      chk("busy_mult_lat", n, 33);
      chk("busy_mult_hi", bus.hi, 32'h0);
      chk("busy_mult_lo", bus.lo, 32'd30);
      // start in the done cycle is accepted
      bus.start = 1'b1; bus.op = MTLO; bus.a = 32'hCAFEF00D;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("done_cycle_mtlo", bus.lo, 32'hCAFEF00D);
      chk("done_cycle_hi", bus.hi, 32'h0);

      // asynchronous reset abandons a long operation
      @(negedge clk);
      bus.start = 1'b1; bus.op = DIV_EN ? DIVU : MULT; bus.a = 32'd100; bus.b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #2;
      chk("rst_mid_busy_before", bus.busy, 1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_hi", bus.hi, 0);
      chk("rst_mid_lo", bus.lo, 0);
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      chk("rst_mid_dbz", bus.div_by_zero, 0);
      @(negedge clk); rstn = 1'b1;

      m_hi = 32'h0; m_lo = 32'h0; m_dz = 1'b0;
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 6));
         ra  = $urandom;
         rb  = $urandom;
         sel = $urandom_range(0, 4);
         case (sel)
            0: rb = 32'($urandom_range(0, 3));
            1: ra = 32'($urandom_range(0, 40));
            2: rb = {32{rb[0]}};
            3: ra = {ra[31], 31'h0};
            default: ;
         endcase
         ref_op(rop, ra, rb, m_hi, m_lo, m_dz, e_hi, e_lo, e_dz, n);
         apply(rop, ra, rb, lat, bcyc);
         chk($sformatf("rnd%0d_op%0d_lat", i, rop), lat, n);
         chk($sformatf("rnd%0d_op%0d_hi", i, rop), bus.hi, e_hi);
         chk($sformatf("rnd%0d_op%0d_lo", i, rop), bus.lo, e_lo);
         chk($sformatf("rnd%0d_op%0d_dbz", i, rop), bus.div_by_zero, e_dz);
         m_hi = e_hi; m_lo = e_lo; m_dz = e_dz;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers; successor to the single-cycle combinational ALU for the MIPS core. Executes MULT/MULTU/DIV/DIVU iteratively (one bit per cycle) and MTHI/MTLO in one cycle. It sits beside the ALU in EX. The core stalls on `busy` and reads `hi`/`lo` directly for MFHI/MFLO.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be ≥ 4.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  operation request; sampled only when `busy`=0.
- `op`  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved (no-op).
- `a`  in  WIDTH  rs operand (dividend / multiplicand / MTHI/MTLO data).
- `b`  in  WIDTH  rt operand (divisor / multiplier).
- `busy`  out  1  operation in flight; new `start` is ignored.
- `done`  out  1  one-cycle pulse: HI/LO result committed this cycle.
- `hi`  out  WIDTH  HI register.
- `lo`  out  WIDTH  LO register.
- `div_by_zero`  out  1  last DIV/DIVU had `b`=0; held until next accepted `start`.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + `start` + MULT/MULTU/DIV/DIVU (b≠0):
  - latch operands; signed ops use absolute values; record result signs.
  - clear the iteration counter, set `busy`=1, go to CALC.
- CALC: one iteration per cycle, WIDTH iterations, then FIX.
  - multiply: shift-add into a 2·WIDTH accumulator.
  - divide: restoring shift-subtract.
- FIX: apply sign correction, write `hi`/`lo`, pulse `done`, clear `busy`, return to IDLE.
- Result mapping:
  - multiply: {hi,lo} = full 2·WIDTH product (signed for MULT).
  - divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV of most-negative by −1: lo = most-negative, hi = 0; no trap.
- DIV/DIVU with `b`=0: no CALC. Next edge: `done`=1, `div_by_zero`=1, hi/lo unchanged, `busy` stays 0.
- MTHI/MTLO in IDLE: `hi`/`lo` ← `a` at the sampling edge. No `busy`, no `done`.
- Reserved op: ignored entirely.
- `hi`/`lo` keep their old values while `busy`; an MFHI during computation returns the pre-op value.
- `start` while `busy`=1: ignored; no queuing.
- `start` in the `done` cycle: accepted (busy=0 there).

## Timing
- Reset (async, `rstn`=0): `hi`=0, `lo`=0, `busy`=0, `done`=0, `div_by_zero`=0, FSM=IDLE. An in-flight op is abandoned with no partial write.
- Accept edge E0; `busy`=1 from E0 through the cycle before E(WIDTH+1).
- Edge E(WIDTH+1): hi/lo written, `done`=1 for exactly one cycle, `busy`=0. Mult/div latency = WIDTH+1 cycles (33 at WIDTH=32).
- Divide-by-zero and disabled-divider paths: `done` at E1.
- MTHI/MTLO: visible on `hi`/`lo` after E0.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `MDU_DIV_EN` defined: divider datapath built; DIV/DIVU behave as above.
- `MDU_DIV_EN` undefined: no divider logic.
  - DIV/DIVU accepted and pulse `done` at E1.
  - hi/lo unchanged, `div_by_zero` stays 0.
  - Multiply and MTHI/MTLO are unaffected.

## Test plan (WIDTH=32, `MDU_DIV_EN` defined unless noted)
- MULT a=0xFFFFFFFD, b=7 → `busy` 33 cycles, then `done` pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then DIVU 7/2 → lo=3, hi=1.
- DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- DIV 5/0 with hi=0x11, lo=0x22 → `done` at E1, `div_by_zero`=1, hi=0x11, lo=0x22. A following MULT start clears `div_by_zero`.
- MULT in flight:
  - MTHI 0x12345678 at cycle 5 → ignored; `hi` still shows the pre-op value until `done`.
  - after `done`, MTLO 0xCAFEF00D → `lo`=0xCAFEF00D next cycle.
- `rstn` low at cycle 10 of a DIVU → all outputs 0 immediately.
- Build without `MDU_DIV_EN` → DIV 9/3 gives `done` at E1 with hi/lo unchanged.
